// File: rtl/definitions_pkg.sv
// -----------------------------------------------------------------------------
// definitions_pkg
//
// Purpose : shared control-bundle definitions for the 5-stage core pipeline.
//           Holds the packed per-stage control bundles and their bubble
//           constants. The bubble constants are the RESET_VAL of the
//           pipe_ctrl_stage registers that carry the bundles, so an invalid
//           slot never asserts a write enable.
//
// Contents:
//   PIPE_STAGES_MAX         deepest supported pipe_ctrl_stage chain
//   ex_ctrl_t / EX_BUBBLE   decode -> execute control bundle
//   mem_ctrl_t / MEM_BUBBLE execute -> memory control bundle
//   wb_ctrl_t / WB_BUBBLE   memory -> writeback control bundle
// -----------------------------------------------------------------------------
package definitions_pkg;

   localparam int PIPE_STAGES_MAX = 4;

   // Writeback result select.
   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

   // Bundle travelling from decode into execute.
   typedef struct packed {
      logic [2:0]  alu_ctrl;
      logic        alu_src;
      logic        branch;
      logic        jump;
      logic        mem_write;
      result_src_e result_src;
      logic        reg_write;
   } ex_ctrl_t;

   // Bundle travelling from execute into memory.
   typedef struct packed {
      result_src_e result_src;
      logic        reg_write;
   } mem_ctrl_t;

   // Bundle travelling from memory into writeback.
   typedef struct packed {
      result_src_e result_src;
      logic        reg_write;
   } wb_ctrl_t;

   // Bubbles: every enable low, so an empty slot is architecturally inert.
   localparam ex_ctrl_t EX_BUBBLE = '{
      alu_ctrl   : 3'b000,
      alu_src    : 1'b0,
      branch     : 1'b0,
      jump       : 1'b0,
      mem_write  : 1'b0,
      result_src : RES_ALU,
      reg_write  : 1'b0
   };

   localparam mem_ctrl_t MEM_BUBBLE = '{
      result_src : RES_ALU,
      reg_write  : 1'b0
   };

   localparam wb_ctrl_t WB_BUBBLE = '{
      result_src : RES_ALU,
      reg_write  : 1'b0
   };

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//
// Purpose : one register slot of a control pipeline: a valid bit plus a
//           payload register. Invalid contents always read back as RESET_VAL,
//           whether they came from reset, flush or loading a bubble.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous reset, active low (highest priority)
//   flush     clear the slot (priority over load)
//   load      capture in_valid/in_data on this edge
//   in_valid  incoming bundle valid
//   in_data   incoming bundle payload
//   valid     slot holds a valid bundle
//   data      slot payload, RESET_VAL when valid is low
// -----------------------------------------------------------------------------
module pipe_slot #(
   parameter int               WIDTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         valid_reg <= 1'b0;
         data_reg  <= RESET_VAL;
      end else if (load) begin
         valid_reg <= in_valid;
         // A bubble overwrites the payload too, so stale data never lingers.
         data_reg  <= in_valid ? in_data : RESET_VAL;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;

endmodule

// File: rtl/pipe_ctrl_stage.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_stage
//
// Purpose : parameterised pipeline register for control bundles between the
//           stages of the 5-stage core. A chain of STAGES pipe_slot registers
//           with valid/ready handshake, hazard stall, hazard flush and a
//           bubble value (RESET_VAL) presented by every invalid slot.
//
// Parameters:
//   WIDTH      payload bits per bundle
//   STAGES     register slots in the chain, 1..PIPE_STAGES_MAX
//   RESET_VAL  payload of an empty slot (reset, flush, bubble)
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous reset, active low; overrides flush and stall
//   valid_i   upstream bundle valid
//   ready_o   block accepts a bundle this cycle (forced high during flush)
//   data_i    upstream payload
//   stall_i   freezes the chain; no movement, no retire
//   flush_i   kills every held bundle; an offered bundle is taken and dropped
//   valid_o   last slot holds a valid bundle
//   ready_i   downstream accepts
//   data_o    last-slot payload, RESET_VAL when valid_o is low
//   count_o   valid bundles held, skid entry included
//
// Build option:
//   PIPE_SKID_EN  adds a one-entry skid register ahead of slot 0. ready_o then
//                 comes from the skid valid flop instead of the combinational
//                 ready_i -> ready_o chain. Undefined: no skid entry.
// -----------------------------------------------------------------------------
module pipe_ctrl_stage
   import definitions_pkg::*;
#(
   parameter int               WIDTH     = $bits(mem_ctrl_t),
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = MEM_BUBBLE
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [WIDTH-1:0]            data_i,
   input  logic                        stall_i,
   input  logic                        flush_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [WIDTH-1:0]            data_o,
   output logic [$clog2(STAGES+2)-1:0] count_o
);

   localparam int CW   = $clog2(STAGES + 2);
   localparam int LAST = STAGES - 1;

   // Slot state, index 0 = input slot, LAST = output slot.
   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  d [STAGES];

   // load[k]: slot k captures its predecessor on this edge.
   logic [STAGES-1:0] load;

   // What slot 0 loads from (input port, or skid entry when present).
   logic             head_valid;
   logic [WIDTH-1:0] head_data;

   logic accept;
   logic retire;

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // -------------------------------------------------------------------------
   // Load enables. A slot may load when it is empty or its content moves on.
   // The output slot moves on when downstream is ready; every other slot moves
   // on exactly when its successor loads. Evaluated from the output end back
   // so the chain collapses bubbles and stays full under ready_i=1.
   // -------------------------------------------------------------------------
   always_comb begin
      load       = '0;
      load[LAST] = (~v[LAST] | ready_i) & ~stall_i;
      for (int k = STAGES - 2; k >= 0; k--) begin
         load[k] = (~v[k] | load[k + 1]) & ~stall_i;
      end
   end

   // Retire: output beat handed downstream. Not retired while stalled even
   // though downstream may sample it.
   assign retire = v[LAST] & ready_i & ~stall_i;

   // -------------------------------------------------------------------------
   // Input side
   // -------------------------------------------------------------------------
`ifdef PIPE_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             skid_load;

   // Ready is the skid-empty flop; flush only ever raises it.
   assign ready_o = ~skid_valid | flush_i;
   assign accept  = valid_i & ~skid_valid;

   // Full skid: empties when slot 0 takes it. Empty skid: parks the incoming
   // beat when slot 0 cannot take it directly (loading a bubble keeps it empty).
   assign skid_load = skid_valid ? load[0] : ~load[0];

   pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .flush    (flush_i),
      .load     (skid_load),
      .in_valid (valid_i & ~skid_valid),
      .in_data  (data_i),
      .valid    (skid_valid),
      .data     (skid_data)
   );

   // A parked beat drains ahead of new input; otherwise input bypasses the
   // skid so an empty skid costs no latency.
   assign head_valid = skid_valid | valid_i;
   assign head_data  = skid_valid ? skid_data : data_i;
`else
   assign ready_o    = load[0] | flush_i;
   assign accept     = valid_i & load[0];
   assign head_valid = valid_i;
   assign head_data  = data_i;
`endif

   // -------------------------------------------------------------------------
   // Slot chain
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_slot
         logic             src_valid;
         logic [WIDTH-1:0] src_data;

         if (gi == 0) begin : g_head
            assign src_valid = head_valid;
            assign src_data  = head_data;
         end else begin : g_body
            assign src_valid = v[gi - 1];
            assign src_data  = d[gi - 1];
         end

         pipe_slot #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_slot (
            .clk      (clk_i),
            .rst_n    (rst_i),
            .flush    (flush_i),
            .load     (load[gi]),
            .in_valid (src_valid),
            .in_data  (src_data),
            .valid    (v[gi]),
            .data     (d[gi])
         );
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Occupancy counter
   // -------------------------------------------------------------------------
   always_comb begin
      count_next = count_reg;
      if (flush_i) begin
         count_next = '0;
      end else if (accept && !retire) begin
         count_next = count_reg + CW'(1);
      end else if (!accept && retire) begin
         count_next = count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. Empty slots already hold RESET_VAL, so data_o needs no mux.
   // -------------------------------------------------------------------------
   assign valid_o = v[LAST];
   assign data_o  = d[LAST];
   assign count_o = count_reg;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_stage
//
// Bench for pipe_ctrl_stage with WIDTH=5, STAGES=3, RESET_VAL=5'h1F.
// A cycle table checks exact per-cycle outputs; scoreboarded sequences check
// ordering, occupancy, backpressure, stall, flush and reset corner cases.
// Works with and without PIPE_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_stage;

   localparam int               W   = 5;
   localparam int               ST  = 3;
   localparam logic [W-1:0]     RV  = 5'h1F;

`ifdef PIPE_SKID_EN
   localparam int EXP_FULL        = ST + 1;
   localparam int EXP_STALL_READY = 1;
`else
   localparam int EXP_FULL        = ST;
   localparam int EXP_STALL_READY = 0;
`endif

   logic         clk;
   logic         rst_i;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] data_i;
   logic         stall_i;
   logic         flush_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] data_o;
   logic [2:0]   count_o;

   pipe_ctrl_stage #(
      .WIDTH     (W),
      .STAGES    (ST),
      .RESET_VAL (RV)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .count_o (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] sbq [$];
   logic         last_ready;
   int           peak;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         rdy;
      logic         stl;
      logic         fl;
      logic         e_vo;
      logic [W-1:0] e_do;
      logic [2:0]   e_cnt;
      logic         e_rdy;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One scoreboarded cycle: drive at negedge, check, update model at the edge.
   task automatic sb_cycle(input logic v, input logic [W-1:0] d, input logic rdy,
                           input logic stl, input logic fl);
      logic [W-1:0] exp;
      @(negedge clk);
      valid_i = v;
      data_i  = d;
      ready_i = rdy;
      stall_i = stl;
      flush_i = fl;
      #1;
      last_ready = ready_o;
      chk("count", 32'(count_o), 32'(sbq.size()));
      if (sbq.size() == 0) begin
         chk("spurious_valid", 32'(valid_o), 32'(0));
      end else if (valid_o && rdy && !stl) begin
         exp = sbq.pop_front();
         chk("data_out", 32'(data_o), 32'(exp));
      end else if (valid_o) begin
         chk("data_hold", 32'(data_o), 32'(sbq[0]));
      end
      if (!valid_o) chk("idle_data", 32'(data_o), 32'(RV));
      if (v && ready_o && !fl) sbq.push_back(d);
      if (fl) sbq.delete();
      if (int'(count_o) > peak) peak = int'(count_o);
      $display("cyc v=%0b d=%0d rdy=%0b stall=%0b flush=%0b -> vo=%0b do=%0d cnt=%0d ro=%0b",
               v, d, rdy, stl, fl, valid_o, data_o, count_o, ready_o);
      @(posedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sbq.size() != 0; k++) sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("drain_empty", 32'(sbq.size()), 32'(0));
      sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // v, d, rdy, stl, fl | e_vo, e_do, e_cnt, e_rdy
      tbl[0]  = '{1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd0, 1'b1};
      tbl[1]  = '{1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd1, 1'b1};
      tbl[2]  = '{1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd2, 1'b1};
      tbl[3]  = '{1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 3'd3, 1'b1};
      tbl[4]  = '{1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 3'd3, 1'b1};
      tbl[5]  = '{1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 3'd2, 1'b1};
      tbl[6]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 3'd2, 1'b1};
      tbl[7]  = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd1, 1'b1};
      tbl[8]  = '{1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 3'd1, 1'b1};
      tbl[9]  = '{1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd0, 1'b1};
      tbl[10] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd1, 1'b1};
      tbl[11] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd1, 1'b1};
      tbl[12] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 3'd1, 1'b1};
      tbl[13] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 3'd1, 1'b1};
      tbl[14] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RV,   3'd0, 1'b1};

      // Reset hold with a valid input offered.
      rst_i   = 1'b0;
      valid_i = 1'b1;
      data_i  = 5'b00111;
      stall_i = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b1;
      last_ready = 1'b0;
      peak = 0;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         chk("rst_valid", 32'(valid_o), 32'(0));
         chk("rst_data",  32'(data_o),  32'(RV));
         chk("rst_count", 32'(count_o), 32'(0));
         chk("rst_ready", 32'(ready_o), 32'(1));
         $display("reset cycle %0d -> vo=%0b do=%0d cnt=%0d ro=%0b", r, valid_o, data_o, count_o, ready_o);
      end
      rst_i   = 1'b1;
      valid_i = 1'b0;

      // Cycle-exact table: latency, bubbles, flush, output hold.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         valid_i = tbl[i].v;
         data_i  = tbl[i].d;
         ready_i = tbl[i].rdy;
         stall_i = tbl[i].stl;
         flush_i = tbl[i].fl;
         #1;
         chk($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_vo));
         chk($sformatf("tbl%0d_data",  i), 32'(data_o),  32'(tbl[i].e_do));
         chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_rdy));
         $display("tbl %0d -> vo=%0b do=%0d cnt=%0d ro=%0b", i, valid_o, data_o, count_o, ready_o);
      end

      // Streaming 1..8 with ready_i=1.
      peak = 0;
      for (int i = 1; i <= 8; i++) sb_cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      drain();
      chk("stream_peak", 32'(peak), 32'(ST));

      // Backpressure: ready_i low while input stays valid.
      for (int i = 0; i < 5; i++) sb_cycle(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0);
      #1;
      chk("bp_ready", 32'(ready_o), 32'(0));
      chk("bp_count", 32'(count_o), 32'(EXP_FULL));
      for (int i = 0; i < 4; i++) sb_cycle(1'b1, W'(i + 6), 1'b1, 1'b0, 1'b0);
      drain();

      // One-cycle stall mid-stream.
      for (int i = 0; i < 8; i++) begin
         sb_cycle(1'b1, W'(10 + i), 1'b1, (i == 3), 1'b0);
         if (i == 3) chk("stall_ready", 32'(last_ready), 32'(EXP_STALL_READY));
      end
      drain();

      // Flush together with stall.
      for (int i = 0; i < 3; i++) sb_cycle(1'b1, W'(20 + i), 1'b1, 1'b0, 1'b0);
      sb_cycle(1'b1, 5'd25, 1'b1, 1'b1, 1'b1);
      #1;
      chk("flush_stall_valid", 32'(valid_o), 32'(0));
      chk("flush_stall_data",  32'(data_o),  32'(RV));
      chk("flush_stall_count", 32'(count_o), 32'(0));
      drain();

      // Flush while a bundle is offered under backpressure: taken and dropped.
      for (int i = 0; i < 4; i++) sb_cycle(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0);
      sb_cycle(1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
      chk("flush_ready", 32'(last_ready), 32'(1));
      for (int i = 0; i < 5; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // ready_i toggling every cycle, random valid/data, occasional stall.
      for (int i = 0; i < 40; i++)
         sb_cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 30)), 1'(i % 2),
                  ($urandom_range(0, 7) == 0), 1'b0);
      drain();

      // Reset mid-transfer, overriding stall.
      for (int i = 0; i < 3; i++) sb_cycle(1'b1, W'(i + 2), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_i   = 1'b0;
      stall_i = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 5'd9;
      @(posedge clk);
      #1;
      chk("midrst_valid", 32'(valid_o), 32'(0));
      chk("midrst_data",  32'(data_o),  32'(RV));
      chk("midrst_count", 32'(count_o), 32'(0));
      $display("mid-transfer reset -> vo=%0b do=%0d cnt=%0d", valid_o, data_o, count_o);
      sbq.delete();
      @(negedge clk);
      rst_i   = 1'b1;
      stall_i = 1'b0;
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) sb_cycle(1'b1, W'(i + 3), 1'b1, 1'b0, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
